rptr_ctrl_ae: RTL and testbench

//   Read-side pointer controller for the async FIFO, successor to the basic read-pointer handler.

---
 rtl/rptr_ctrl_ae.sv | 83 ++++++++
 tb/tb_rptr_ctrl_ae.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rptr_ctrl_ae.sv
// rptr_ctrl_ae: read-side pointer controller for an async FIFO (rclk domain).
// Ports:
//   rclk, rrst (async, active-high), r_en, uf_clr, g_wptr_sync (synced Gray wptr)
//   b_rptr, g_rptr, r_addr, empty, almost_empty, rd_count, underflow
module rptr_ctrl_ae #(
    parameter int PTR_WIDTH = 3,
    parameter int AE_THRESH = 1
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 r_en,
    input  logic                 uf_clr,
    input  logic [PTR_WIDTH:0]   g_wptr_sync,
    output logic [PTR_WIDTH:0]   b_rptr,
    output logic [PTR_WIDTH:0]   g_rptr,
    output logic [PTR_WIDTH-1:0] r_addr,
    output logic                 empty,
    output logic                 almost_empty,
    output logic [PTR_WIDTH:0]   rd_count,
    output logic                 underflow
);

    localparam int W = PTR_WIDTH + 1;
    localparam logic [W-1:0] AE_T = W'(AE_THRESH);

    // Gray to binary: each bit is the XOR of all Gray bits at or above it.
    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic           rd_fire;
    logic [W-1:0]   b_next;
    logic [W-1:0]   g_next;
    logic [W-1:0]   w_bin;
    logic [W-1:0]   occ_next;
    logic           empty_next;
    logic           ae_next;
    logic           uf_next;

    always_comb begin
        rd_fire    = r_en & ~empty;
        b_next     = b_rptr + {{PTR_WIDTH{1'b0}}, rd_fire};
        g_next     = b_next ^ (b_next >> 1);
        w_bin      = gray2bin(g_wptr_sync);
        // Modulo subtraction: wrap bit makes a full FIFO read as DEPTH.
        occ_next   = w_bin - b_next;
        empty_next = (g_next == g_wptr_sync);
        ae_next    = (occ_next <= AE_T);
        // A new underflow event outranks a simultaneous clear.
        uf_next    = underflow;
        if (r_en & empty) begin
            uf_next = 1'b1;
        end else if (uf_clr) begin
            uf_next = 1'b0;
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            b_rptr       <= '0;
            g_rptr       <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_count     <= '0;
            underflow    <= 1'b0;
        end else begin
            b_rptr       <= b_next;
            g_rptr       <= g_next;
            empty        <= empty_next;
            almost_empty <= ae_next;
            rd_count     <= occ_next;
            underflow    <= uf_next;
        end
    end

    assign r_addr = b_rptr[PTR_WIDTH-1:0];

endmodule

// File: tb/tb_rptr_ctrl_ae.sv
// tb_rptr_ctrl_ae: scoreboard bench for rptr_ctrl_ae (PTR_WIDTH=3, AE_THRESH=1).
// Stimulus pushes expected results; a monitor pops and compares after each edge.
module tb_rptr_ctrl_ae;

    localparam int PW    = 3;
    localparam int DEPTH = 8;
    localparam int AE    = 1;

    logic          rclk;
    logic          rrst;
    logic          r_en;
    logic          uf_clr;
    logic [PW:0]   g_wptr_sync;
    logic [PW:0]   b_rptr;
    logic [PW:0]   g_rptr;
    logic [PW-1:0] r_addr;
    logic          empty;
    logic          almost_empty;
    logic [PW:0]   rd_count;
    logic          underflow;

    rptr_ctrl_ae #(.PTR_WIDTH(PW), .AE_THRESH(AE)) dut (
        .rclk(rclk),
        .rrst(rrst),
        .r_en(r_en),
        .uf_clr(uf_clr),
        .g_wptr_sync(g_wptr_sync),
        .b_rptr(b_rptr),
        .g_rptr(g_rptr),
        .r_addr(r_addr),
        .empty(empty),
        .almost_empty(almost_empty),
        .rd_count(rd_count),
        .underflow(underflow)
    );

    typedef struct {
        int b;
        int g;
        int addr;
        int emp;
        int ae;
        int cnt;
        int uf;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: total reads/writes as plain counters, flags derived from them.
    int m_rd;
    int m_wr;
    int m_empty;
    int m_uf;

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int to_gray(input int v);
        return (v ^ (v >> 1)) & 15;
    endfunction

    task automatic model_reset();
        m_rd    = 0;
        m_empty = 1;
        m_uf    = 0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " b_rptr"}, int'(b_rptr), 0);
        chk({tag, " g_rptr"}, int'(g_rptr), 0);
        chk({tag, " empty"}, int'(empty), 1);
        chk({tag, " almost_empty"}, int'(almost_empty), 1);
        chk({tag, " rd_count"}, int'(rd_count), 0);
        chk({tag, " underflow"}, int'(underflow), 0);
    endtask

    // Entered at posedge+2; drives one cycle and queues what the next edge must show.
    task automatic cycle(input bit re, input bit clr, input int wr, input string tag);
        exp_t e;
        int occ;
        bit fire;
        m_wr        = wr;
        r_en        = re;
        uf_clr      = clr;
        g_wptr_sync = 4'(to_gray(wr & 15));
        fire = re && (m_empty == 0);
        if (re && m_empty != 0) m_uf = 1;
        else if (clr) m_uf = 0;
        if (fire) m_rd++;
        occ = (m_wr - m_rd) & 15;
        m_empty = (occ == 0) ? 1 : 0;
        e.b    = m_rd & 15;
        e.g    = to_gray(m_rd & 15);
        e.addr = m_rd % DEPTH;
        e.emp  = m_empty;
        e.ae   = (occ <= AE) ? 1 : 0;
        e.cnt  = occ;
        e.uf   = m_uf;
        e.tag  = tag;
        exp_q.push_back(e);
        @(posedge rclk);
        #2;
    endtask

    always begin
        exp_t e;
        @(posedge rclk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.tag, " b_rptr"}, int'(b_rptr), e.b);
            chk({e.tag, " g_rptr"}, int'(g_rptr), e.g);
            chk({e.tag, " r_addr"}, int'(r_addr), e.addr);
            chk({e.tag, " empty"}, int'(empty), e.emp);
            chk({e.tag, " almost_empty"}, int'(almost_empty), e.ae);
            chk({e.tag, " rd_count"}, int'(rd_count), e.cnt);
            chk({e.tag, " underflow"}, int'(underflow), e.uf);
        end
    end

    initial begin
        int wr;
        rrst        = 1'b1;
        r_en        = 1'b0;
        uf_clr      = 1'b0;
        g_wptr_sync = '0;
        m_wr        = 0;
        model_reset();
        #3;
        chk_reset("reset");
        @(posedge rclk);
        #2;
        rrst = 1'b0;

        cycle(1'b0, 1'b0, 5, "fill");
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 5, "drain");
        cycle(1'b1, 1'b1, 5, "prio_set");
        cycle(1'b0, 1'b1, 5, "prio_clr");

        // Full and wrap: restart from pointer 0.
        #1;
        rrst = 1'b1;
        #1;
        model_reset();
        chk_reset("rst2");
        rrst = 1'b0;
        @(posedge rclk);
        #2;
        cycle(1'b0, 1'b0, 8, "full");
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8, "wrap1");
        cycle(1'b0, 1'b0, 16, "full2");
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 16, "wrap2");

        // Async reset during a read burst, between edges.
        cycle(1'b0, 1'b0, 21, "burst_fill");
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 21, "burst");
        #1;
        rrst = 1'b1;
        #1;
        chk_reset("async");
        model_reset();
        rrst = 1'b0;
        g_wptr_sync = 4'(to_gray(5));
        #1;
        cycle(1'b0, 1'b0, 5, "recover");

        // Random traffic: writer never exceeds DEPTH ahead of the reader.
        wr = 5;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 1) == 1 && (wr - m_rd) < DEPTH) wr++;
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), wr, "rand");
        end

        r_en = 1'b0;
        repeat (3) @(posedge rclk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
